valu_arbiter: RTL and testbench
===============================

# valu_arbiter

Two-port arbiter and sequencer for the shared 64-bit vector ALU. It accepts vector R-type requests from two requesters over valid/ready handshakes and grants them round-robin. It drives the ALU's operand, function and width inputs from registers for a function-dependent number of cycles, then captures the ALU result and returns it to the granted requester with backpressure. It sits between the issue logic and the combinational ALU. Multicycle functions (multiply, square, divide, modulo, square root) therefore get a guaranteed hold window rather than a single-cycle path.

## Interface
- MUL_CYCLES, 2: hold cycles for VMULEU, VMULOU, VSQEU, VSQOU (legal range 1..15)
- DIV_CYCLES, 4: hold cycles for VDIV, VMOD, VSQRT (legal range 1..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- reqN_valid  in  1  request valid, N = 0, 1
- reqN_ready  out  1  request accepted this cycle, N = 0, 1
- reqN_rA, reqN_rB  in  [0:63]  operands
- reqN_func  in  [0:5]  R-type function code
- reqN_ww  in  [0:1]  element width: 00 = 8, 01 = 16, 10 = 32, 11 = 64
- alu_rA, alu_rB  out  [0:63]  registered ALU operands
- alu_R_ins  out  [0:5]  registered function code
- alu_WW  out  [0:1]  registered width
- alu_Op_code  out  [0:5]  constant 6'b101010
- alu_out  in  [0:63]  ALU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index of the response
- rsp_data  out  [0:63]  captured result
- rsp_err  out  1  function code outside 000001..010010
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: arbitrate.
  - One valid request: that requester is granted.
  - Both valid: grant goes to the requester not equal to last_grant.
  - reqN_ready = 1 only for the granted requester, and only in IDLE; it is combinational from the valids and last_grant.
  - On transfer (valid & ready): latch operands, func and ww into the alu_* registers; set rsp_id and last_grant to N; load cnt = L-1; go to BUSY.
- L by func:
  - 000001–000111 and 001010–001101: L = 1.
  - 001000, 001001, 010000, 010001: L = MUL_CYCLES.
  - 001110, 001111, 010010: L = DIV_CYCLES.
  - Any other code: L = 1, with rsp_err set.
- BUSY: the alu_* registers are held constant.
  - cnt != 0: decrement cnt.
  - cnt == 0: rsp_data <= alu_out; rsp_err set per func; go to DONE.
- DONE: rsp_valid = 1; rsp_data, rsp_id and rsp_err are held stable.
  - rsp_ready = 1: go to IDLE.
  - Otherwise stay in DONE; both reqN_ready stay 0.
- Request inputs are ignored outside IDLE. Requesters hold valid and payload until ready.
- alu_* registers keep the last operation's values in IDLE and DONE; they are not cleared.

## Timing
- Reset values:
  - FSM = IDLE, last_grant = 1 (req0 wins the first tie), cnt = 0.
  - reqN_ready = 0 while reset is high.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, busy = 0.
  - alu_rA = alu_rB = 0, alu_R_ins = 0, alu_WW = 0.
  - alu_Op_code = 6'b101010 always.
- Latency: request accepted at edge E0; rsp_valid rises at edge E0+L.
- Throughput: one operation per L+2 cycles minimum (accept, L BUSY cycles, one DONE cycle with rsp_ready high, back in IDLE).
- Simultaneous requests from both ports alternate strictly. A lone requester may be granted back-to-back.
- Reset asserted in BUSY or DONE: the in-flight operation is dropped, no response is issued, and the next cycle is IDLE with reset values.
- rsp_ready high in a cycle where rsp_valid is low has no effect.

## Test plan
- VAND, single port:
  - Stimulus: req0 func 000001, rA = 15, rB = 14, ww = 10.
  - Required: req0_ready = 1 in the first IDLE cycle; rsp_valid 1 cycle after acceptance with rsp_data = 14, rsp_id = 0, rsp_err = 0.
- VDIV latency (DIV_CYCLES = 4):
  - Stimulus: req1 func 001110, rA = 64'hFF00FF00_FF00FF00, rB = 64'h11221122_44444444, ww = 00.
  - Required: alu_* inputs held stable for 4 cycles; rsp_valid exactly 4 cycles after acceptance with rsp_id = 1.
- Tie, round-robin:
  - Stimulus: both ports valid continuously, rsp_ready = 1.
  - Required: grants go req0, req1, req0, req1; each requester sees ready only in its grant cycle.
- Backpressure:
  - Stimulus: VOR 15|14, with rsp_ready held 0 for 5 cycles.
  - Required: rsp_valid = 1 with rsp_data = 15 stable for all 5 cycles; both reqN_ready = 0; IDLE entered the cycle after rsp_ready rises.
- Reset mid-operation:
  - Stimulus: assert reset in the 2nd BUSY cycle of a VSQRT.
  - Required: no rsp_valid pulse; all outputs at reset values; the next request is accepted normally with req0 winning a tie.
- Illegal function:
  - Stimulus: func 111111.
  - Required: rsp_valid after 1 cycle with rsp_err = 1.

Source files
------------

// File: rtl/valu_arbiter.sv
// Round-robin two-port arbiter and operand sequencer for the shared vector ALU.
// Holds ALU inputs for L cycles (1/MUL/DIV) and then returns a response; the response is held in DONE until rsp_ready.
module valu_arbiter #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [0:63] req0_rA,
  input  logic [0:63] req0_rB,
  input  logic [0:5]  req0_func,
  input  logic [0:1]  req0_ww,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [0:63] req1_rA,
  input  logic [0:63] req1_rB,
  input  logic [0:5]  req1_func,
  input  logic [0:1]  req1_ww,
  output logic [0:63] alu_rA,
  output logic [0:63] alu_rB,
  output logic [0:5]  alu_R_ins,
  output logic [0:1]  alu_WW,
  output logic [0:5]  alu_Op_code,
  input  logic [0:63] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [0:63] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic [3:0]  cnt;
  logic        gnt0, gnt1, accept, sel;
  logic [0:5]  sel_func;

  // Hold length per function code; codes outside 1..18 run one cycle and flag an error.
  function automatic logic [3:0] func_len(input logic [0:5] f);
    logic [3:0] len;
    len = 4'd1;
    if (f == 6'd8 || f == 6'd9 || f == 6'd16 || f == 6'd17)
      len = 4'(MUL_CYCLES);
    else if (f == 6'd14 || f == 6'd15 || f == 6'd18)
      len = 4'(DIV_CYCLES);
    return len;
  endfunction

  function automatic logic func_err(input logic [0:5] f);
    return (f == 6'd0) || (f > 6'd18);
  endfunction

  // The side that did not win last time takes a tie.
  assign gnt0       = req0_valid & (~req1_valid | last_grant);
  assign gnt1       = req1_valid & (~req0_valid | ~last_grant);
  assign req0_ready = (state == IDLE) & ~reset & gnt0;
  assign req1_ready = (state == IDLE) & ~reset & gnt1;
  assign accept     = req0_ready | req1_ready;
  assign sel        = req1_ready;
  assign sel_func   = sel ? req1_func : req0_func;

  assign rsp_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign alu_Op_code = 6'b101010;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    if (rsp_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      alu_rA     <= '0;
      alu_rB     <= '0;
      alu_R_ins  <= '0;
      alu_WW     <= '0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_rA     <= sel ? req1_rA : req0_rA;
            alu_rB     <= sel ? req1_rB : req0_rB;
            alu_R_ins  <= sel_func;
            alu_WW     <= sel ? req1_ww : req0_ww;
            rsp_id     <= sel;
            last_grant <= sel;
            cnt        <= func_len(sel_func) - 4'd1;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data <= alu_out;
            rsp_err  <= func_err(alu_R_ins);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_valu_arbiter.sv
// Directed bench for valu_arbiter with a stand-in ALU (1: AND, 2: OR, other: XOR).
module tb_valu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [0:63] req0_rA, req0_rB, req1_rA, req1_rB;
  logic [0:5]  req0_func, req1_func;
  logic [0:1]  req0_ww, req1_ww;
  logic [0:63] alu_rA, alu_rB, alu_out;
  logic [0:5]  alu_R_ins, alu_Op_code;
  logic [0:1]  alu_WW;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [0:63] rsp_data;

  int checks = 0;
  int errors = 0;

  valu_arbiter #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rA(req0_rA), .req0_rB(req0_rB),
    .req0_func(req0_func), .req0_ww(req0_ww),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rA(req1_rA), .req1_rB(req1_rB),
    .req1_func(req1_func), .req1_ww(req1_ww),
    .alu_rA(alu_rA), .alu_rB(alu_rB), .alu_R_ins(alu_R_ins), .alu_WW(alu_WW),
    .alu_Op_code(alu_Op_code), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out = alu_rA ^ alu_rB;
    if (alu_R_ins == 6'd1) alu_out = alu_rA & alu_rB;
    else if (alu_R_ins == 6'd2) alu_out = alu_rA | alu_rB;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input bit port, input logic [5:0] func,
                       input logic [63:0] a, input logic [63:0] b, input logic [1:0] ww,
                       input int lat, input logic [63:0] exp_data, input logic exp_err);
    @(negedge clk);
    if (port == 1'b0) begin
      req0_valid = 1'b1; req0_func = func; req0_rA = a; req0_rB = b; req0_ww = ww;
    end else begin
      req1_valid = 1'b1; req1_func = func; req1_rA = a; req1_rB = b; req1_ww = ww;
    end
    rsp_ready = 1'b0;
    #1;
    check({tag, " ready0"}, 64'(req0_ready), 64'(port == 1'b0));
    check({tag, " ready1"}, 64'(req1_ready), 64'(port == 1'b1));
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, " hold rA"}, alu_rA, a);
      check({tag, " hold rB"}, alu_rB, b);
      check({tag, " hold func"}, 64'(alu_R_ins), 64'(func));
      check({tag, " hold ww"}, 64'(alu_WW), 64'(ww));
      check({tag, " early valid"}, 64'(rsp_valid), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, " rsp_data"}, rsp_data, exp_data);
    check({tag, " rsp_id"}, 64'(rsp_id), 64'(port));
    check({tag, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " back idle"}, 64'(busy), 64'd0);
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, " rsp_id"}, 64'(rsp_id), 64'd0);
    check({tag, " rsp_data"}, rsp_data, 64'd0);
    check({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " alu_rA"}, alu_rA, 64'd0);
    check({tag, " alu_rB"}, alu_rB, 64'd0);
    check({tag, " alu_R_ins"}, 64'(alu_R_ins), 64'd0);
    check({tag, " alu_WW"}, 64'(alu_WW), 64'd0);
    check({tag, " op_code"}, 64'(alu_Op_code), 64'h2A);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_rA = '0; req0_rB = '0; req0_func = '0; req0_ww = '0;
    req1_rA = '0; req1_rB = '0; req1_func = '0; req1_ww = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    check("reset ready0", 64'(req0_ready), 64'd0);
    check("reset ready1", 64'(req1_ready), 64'd0);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    do_op("vand", 1'b0, 6'd1, 64'd15, 64'd14, 2'b10, 1, 64'd14, 1'b0);
    do_op("vdiv", 1'b1, 6'd14, 64'hFF00FF00_FF00FF00, 64'h11221122_44444444, 2'b00, 4,
          64'hEE22EE22_BB44BB44, 1'b0);

    // Tie: both ports valid throughout, grants must alternate starting with req0.
    @(negedge clk);
    req0_valid = 1'b1; req0_func = 6'd1; req0_rA = 64'd15;   req0_rB = 64'd14;   req0_ww = 2'b11;
    req1_valid = 1'b1; req1_func = 6'd1; req1_rA = 64'hF0;   req1_rB = 64'h3C;   req1_ww = 2'b01;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      check("tie idle ready0", 64'(req0_ready), 64'(g % 2 == 0));
      check("tie idle ready1", 64'(req1_ready), 64'(g % 2 == 1));
      @(posedge clk);
      @(negedge clk);
      check("tie busy readies", 64'({req0_ready, req1_ready}), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check("tie rsp_valid", 64'(rsp_valid), 64'd1);
      check("tie rsp_id", 64'(rsp_id), 64'(g % 2));
      check("tie rsp_data", rsp_data, (g % 2 == 0) ? 64'd14 : 64'h30);
      check("tie done readies", 64'({req0_ready, req1_ready}), 64'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

    // Backpressure: VOR 15|14 held in DONE while a competing request waits.
    req0_valid = 1'b1; req0_func = 6'd2; req0_rA = 64'd15; req0_rB = 64'd14; req0_ww = 2'b10;
    #1;
    check("bp ready0", 64'(req0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_func = 6'd1; req1_rA = 64'd3; req1_rB = 64'd1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp rsp_data", rsp_data, 64'd15);
      check("bp readies", 64'({req0_ready, req1_ready}), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp still valid", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp idle", 64'(busy), 64'd0);
    check("bp waiting ready1", 64'(req1_ready), 64'd1);
    req1_valid = 1'b0; rsp_ready = 1'b0;

    // Reset in the second BUSY cycle of a VSQRT from req0 (so last_grant was 0).
    req0_valid = 1'b1; req0_func = 6'd18; req0_rA = 64'd7; req0_rB = 64'd3; req0_ww = 2'b11;
    #1;
    check("rst ready0", 64'(req0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    check("rst busy1", 64'(busy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst busy2", 64'(busy), 64'd1);
    reset = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst no rsp", 64'(rsp_valid), 64'd0);
    end
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("midrst tie ready0", 64'(req0_ready), 64'd1);
    check("midrst tie ready1", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    do_op("post", 1'b0, 6'd1, 64'd12, 64'd10, 2'b00, 1, 64'd8, 1'b0);
    do_op("vmul", 1'b0, 6'd8, 64'd3, 64'd5, 2'b01, 2, 64'd6, 1'b0);
    do_op("illegal", 1'b1, 6'd63, 64'hA5, 64'h0F, 2'b00, 1, 64'hAA, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
